// File: rtl/iir_allpole_pkg.sv
// Shared types and arithmetic helpers for the serial all-pole IIR filter.
// round_sat is kept generic so other filter blocks can reuse it.
package iir_allpole_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_RESULT,
    S_OUT
  } state_e;

  localparam int RS_W = 64;

  function automatic int acc_width(
    input int in_w,
    input int out_w,
    input int coeff_w,
    input int frac,
    input int taps
  );
    int a;
    int b;
    a = in_w + frac;
    b = out_w + coeff_w;
    return ((a > b) ? a : b) + $clog2(taps + 1) + 1;
  endfunction

  // Round half up (arithmetic shift), then clamp to out_w signed.
  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     frac,
    input int                     out_w
  );
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Result stage of the all-pole IIR: rounding and output saturation.
// Purely combinational.
module iir_round_sat
  import iir_allpole_pkg::*;
#(
  parameter int ACC_W     = 15,
  parameter int OUT_WIDTH = 8,
  parameter int FRAC_BITS = 2
) (
  input  logic signed [ACC_W-1:0]     acc_i,
  output logic signed [OUT_WIDTH-1:0] sat_o
);

  logic signed [RS_W-1:0] wide;

  assign wide  = RS_W'(acc_i);
  assign sat_o = OUT_WIDTH'(round_sat(wide, FRAC_BITS, OUT_WIDTH));

endmodule

// File: rtl/iir_allpole_serial.sv
// Serial all-pole IIR: y = sat(round(x - sum a_k*y[n-k])).
// One multiplier shared over the taps, one coefficient per cycle.
module iir_allpole_serial
  import iir_allpole_pkg::*;
#(
  parameter int IN_WIDTH    = 9,
  parameter int OUT_WIDTH   = 8,
  parameter int COEFF_WIDTH = 4,
  parameter int FRAC_BITS   = 2,
  parameter int NUM_TAPS    = 2,
  parameter logic [NUM_TAPS*COEFF_WIDTH-1:0] COEFFS = 8'h1E
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] data_out
);

  localparam int ACC_W = acc_width(IN_WIDTH, OUT_WIDTH,
                                   COEFF_WIDTH, FRAC_BITS,
                                   NUM_TAPS);
  localparam int KW = $clog2(NUM_TAPS + 1);

  state_e                      state_q, state_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic        [KW-1:0]        k_q, k_d;
  logic signed [OUT_WIDTH-1:0] hist_q [NUM_TAPS];
  logic signed [OUT_WIDTH-1:0] hist_d [NUM_TAPS];
  logic signed [OUT_WIDTH-1:0] dout_q, dout_d;

  logic signed [COEFF_WIDTH-1:0] coef;
  logic signed [OUT_WIDTH-1:0]   hv;
  logic signed [ACC_W-1:0]       prod;
  logic signed [OUT_WIDTH-1:0]   sat;

  iir_round_sat #(
    .ACC_W     (ACC_W),
    .OUT_WIDTH (OUT_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_rs (
    .acc_i (acc_q),
    .sat_o (sat)
  );

  // Tap select: k is 1-based, so slice k-1 / hist[k-1].
  always_comb begin
    coef = '0;
    hv   = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (k_q == KW'(i + 1)) begin
        coef = signed'(COEFFS[i*COEFF_WIDTH +: COEFF_WIDTH]);
        hv   = hist_q[i];
      end
    end
    prod = ACC_W'(coef) * ACC_W'(hv);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    dout_d  = dout_q;
    for (int i = 0; i < NUM_TAPS; i++) begin
      hist_d[i] = hist_q[i];
    end
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          acc_d   = ACC_W'(data_in) <<< FRAC_BITS;
          k_d     = KW'(1);
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q - prod;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(NUM_TAPS)) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        dout_d = sat;
        for (int i = NUM_TAPS - 1; i > 0; i--) begin
          hist_d[i] = hist_q[i-1];
        end
        hist_d[0] = sat;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      dout_q  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist_q[i] <= '0;
      end
    end else if (en) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      dout_q  <= dout_d;
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_iir_allpole_serial.sv
// Bench for iir_allpole_serial: vector table, corner sequences,
// random stream against an integer model, FIR round trip.
module tb_iir_allpole_serial;

  logic              clk;
  logic              rst_b;
  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic signed [8:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] data_out;

  int passed;
  int total;
  int mh [2];

  localparam int A1 = -2;
  localparam int A2 = 1;

  iir_allpole_serial dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q--;
    return q;
  endfunction

  function automatic void model_reset();
    mh[0] = 0;
    mh[1] = 0;
  endfunction

  // y = clamp(floor((4x - a1*y1 - a2*y2 + 2) / 4))
  function automatic int model_step(input int x);
    int acc;
    int r;
    acc = x * 4 - A1 * mh[0] - A2 * mh[1];
    r   = floordiv(acc + 2, 4);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    mh[1] = mh[0];
    mh[0] = r;
    return r;
  endfunction

  task automatic do_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Called at a negedge; returns at a negedge after the output handshake.
  task automatic xfer(input int x, input int stall_at,
                      output int y, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    data_in  = 9'(x);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      if (n == stall_at) en = 1'b0;
      if (n == stall_at + 2) en = 1'b1;
      @(negedge clk);
      n++;
    end
    en        = 1'b1;
    lat       = n;
    y         = data_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int x;
    int y;
  } vec_t;

  initial begin
    vec_t vt [7];
    int   y;
    int   lat;
    int   y0;
    int   ok;
    int   e;
    int   xs [3];

    vt[0] = '{8, 8};
    vt[1] = '{0, 4};
    vt[2] = '{0, 0};
    vt[3] = '{0, -1};
    vt[4] = '{255, 127};
    vt[5] = '{0, 64};
    vt[6] = '{-256, -128};

    passed    = 0;
    total     = 0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    rst_b     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_data_out", int'(data_out), 0);
    rst_b = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      xfer(vt[i].x, -1, y, lat);
      void'(model_step(vt[i].x));
      check($sformatf("vec%0d_y", i), y, vt[i].y);
      check($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Backpressure: output held, input ignored.
    data_in  = 9'sd5;
    in_valid = 1'b1;
    @(negedge clk);
    data_in = 9'sd99;
    e = 0;
    while (!out_valid && e < 50) begin
      @(negedge clk);
      e++;
    end
    y0 = data_out;
    check("bp_y", y0, model_step(5));
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (data_out != 8'(y0) || in_ready || !out_valid) ok = 0;
    end
    check("bp_hold", ok, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready", int'(in_ready), 1);
    check("bp_out_valid", int'(out_valid), 0);

    // Stall two cycles during MAC.
    xfer(17, 0, y, lat);
    check("stall_y", y, model_step(17));
    check("stall_lat", lat, 5);

    // Reset in the middle of MAC.
    do_reset();
    xfer(8, -1, y, lat);
    check("pre_rst_y", y, model_step(8));
    data_in  = 9'sd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_data_out", int'(data_out), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    @(negedge clk);
    xfer(8, -1, y, lat);
    check("post_rst_y", y, 8);
    void'(model_step(8));

    // Random stream against the model.
    for (int i = 0; i < 40; i++) begin
      int x;
      x = int'($urandom_range(0, 511)) - 256;
      xfer(x, -1, y, lat);
      check($sformatf("rnd%0d_y", i), y, model_step(x));
      check($sformatf("rnd%0d_lat", i), lat, 3);
    end

    // Round trip through the matching FIR 1 - 0.5z^-1 + 0.25z^-2.
    do_reset();
    xs[0] = 0;
    xs[1] = 0;
    xs[2] = 0;
    for (int i = 0; i < 30; i++) begin
      int v;
      int d;
      xs[2] = xs[1];
      xs[1] = xs[0];
      xs[0] = (int'($urandom_range(0, 63)) - 32) * 4;
      v = xs[0] - xs[1] / 2 + xs[2] / 4;
      xfer(v, -1, y, lat);
      check($sformatf("rt%0d_model", i), y, model_step(v));
      d = y - xs[0];
      check($sformatf("rt%0d_tol", i), int'(d >= -1 && d <= 1), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
